// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: fixed busy latency per operation, mthi/mtlo moves, mfhi/mflo read port.
// Optional build macro MULDIV_DIVZERO_KEEP_EN: a divide by zero leaves HI/LO untouched instead of writing LO=all ones, HI=a.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             move_to,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2:0] SEL_HI = 3'd4;
    localparam logic [2:0] SEL_LO = 3'd5;

`ifdef MULDIV_DIVZERO_KEEP_EN
    localparam bit DIVZERO_KEEP = 1'b1;
`else
    localparam bit DIVZERO_KEEP = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_target;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] mul_p;
    logic [2*WIDTH-1:0] div_p;
    logic               accept;

    // Full-width product: operands are sign- or zero-extended to 2*WIDTH first.
    function automatic logic [2*WIDTH-1:0] mul_result(input logic is_unsigned,
                                                      input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] ex;
        logic [2*WIDTH-1:0] ey;
        if (is_unsigned) begin
            ex = {{WIDTH{1'b0}}, x};
            ey = {{WIDTH{1'b0}}, y};
        end else begin
            ex = {{WIDTH{x[WIDTH-1]}}, x};
            ey = {{WIDTH{y[WIDTH-1]}}, y};
        end
        return ex * ey;
    endfunction

    // Returns {remainder, quotient}; zero divisor and signed overflow are resolved explicitly.
    function automatic logic [2*WIDTH-1:0] div_result(input logic is_unsigned,
                                                      input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        logic [WIDTH-1:0]        q;
        logic [WIDTH-1:0]        r;
        sx = x;
        sy = y;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (is_unsigned) begin
            q = x / y;
            r = x % y;
        end else if (x == MOST_NEG && y == '1) begin
            q = MOST_NEG;
            r = '0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        return {r, q};
    endfunction

    assign cnt_target = op_q[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    assign mul_p      = mul_result(op_q[0], a_q, b_q);
    assign div_p      = div_result(op_q[0], a_q, b_q);
    assign accept     = start && !sel[2];

    always_comb begin
        rdata = '0;
        if (sel == SEL_HI)
            rdata = hi;
        else if (sel == SEL_LO)
            rdata = lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= sel[1:0];
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (move_to) begin
                        if (sel == SEL_HI)
                            hi <= a;
                        else if (sel == SEL_LO)
                            lo <= a;
                    end
                end
                RUN: begin
                    // cnt holds the index of the busy cycle now ending; the last one commits the result.
                    if (cnt == cnt_target) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!op_q[1])
                            {hi, lo} <= mul_p;
                        else if (!(DIVZERO_KEEP && b_q == '0))
                            {hi, lo} <= div_p;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a negedge monitor pops them when busy falls.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         move_to;
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rdata;

    muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .move_to(move_to), .sel(sel),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           len;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 64-bit integer arithmetic; returns {hi, lo} after the operation.
    function automatic logic [2*W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic [2*W-1:0] cur);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     q;
        logic [63:0]     r;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        if (op == 3'd0) return sx * sy;
        if (op == 3'd1) return ux * uy;
        if (y == 0) begin
`ifdef MULDIV_DIVZERO_KEEP_EN
            return cur;
`else
            return {x, {W{1'b1}}};
`endif
        end
        if (op == 3'd2) begin
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = ux / uy;
            r = ux % uy;
        end
        return {r[W-1:0], q[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic push_exp(input string name, input logic [2:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] r;
        r = ref_op(op, x, y, {m_hi, m_lo});
        e.name = name;
        e.hi = r[2*W-1:W];
        e.lo = r[W-1:0];
        e.len = (op < 3'd2) ? MUL_N : DIV_N;
        {m_hi, m_lo} = r;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, k);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        push_exp(name, op, x, y);
        start = 1'b1; sel = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; sel = 3'd7; a = $urandom; b = $urandom;
        wait_idle(name);
    endtask

    task automatic do_move(input string name, input logic [2:0] s, input logic [W-1:0] x);
        move_to = 1'b1; sel = s; a = x;
        #1;
        check({name, "_pre"}, (s == 3'd4) ? hi : lo, (s == 3'd4) ? m_hi : m_lo);
        @(posedge clk); #1;
        move_to = 1'b0;
        if (s == 3'd4) m_hi = x;
        else if (s == 3'd5) m_lo = x;
        check({name, "_hi"}, hi, m_hi);
        check({name, "_lo"}, lo, m_lo);
        check({name, "_rdata"}, rdata, (s == 3'd4) ? m_hi : (s == 3'd5) ? m_lo : '0);
        sel = 3'd7;
    endtask

    // Monitor: a falling busy marks a completed operation.
    int   run_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_len = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_completion: hi=%h lo=%h with no operation pending", hi, lo);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    check({e.name, "_busy_len"}, run_len, e.len);
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; move_to = 1'b0; sel = 3'd7; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        sel = 3'd4; #1;
        check("rst_rdata_hi", rdata, 0);
        sel = 3'd7;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3);
        do_op("multu_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3);
        do_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_7_2", 3'd3, 32'd7, 32'd2);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_by0", 3'd3, 32'd5, 32'd0);

        do_move("mthi", 3'd4, 32'h1234_5678);
        do_move("mtlo", 3'd5, 32'h9ABC_DEF0);
        sel = 3'd4; #1; check("rdata_sel4", rdata, m_hi);
        sel = 3'd5; #1; check("rdata_sel5", rdata, m_lo);
        sel = 3'd7; #1; check("rdata_sel7", rdata, 0);
        do_move("move_sel6", 3'd6, 32'hDEAD_BEEF);

        start = 1'b1; sel = 3'd6; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; sel = 3'd7;
        check("start_sel6_busy", busy, 0);
        check("start_sel6_hi", hi, m_hi);

        // Start and move_to during a multiply are both dropped.
        push_exp("mult_stall", 3'd0, 32'h0000_1234, 32'hFFFF_0003);
        start = 1'b1; sel = 3'd0; a = 32'h0000_1234; b = 32'hFFFF_0003;
        @(posedge clk); #1;
        start = 1'b1; move_to = 1'b1; sel = 3'd2; a = 32'h55; b = 32'h3;
        @(posedge clk); #1;
        start = 1'b0; sel = 3'd4; a = 32'hAAAA_5555;
        @(posedge clk); #1;
        move_to = 1'b0; sel = 3'd7;
        wait_idle("mult_stall");
        repeat (12) @(posedge clk);
        #1;
        check("stall_no_relaunch", busy, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 3));
            do_op($sformatf("rand%0d_op%0d", i, op), op, pick(), pick());
        end

        // Reset in the third busy cycle of a divide discards the pending result.
        do_move("pre_rst_hi", 3'd4, 32'hCAFE_0001);
        do_move("pre_rst_lo", 3'd5, 32'hCAFE_0002);
        start = 1'b1; sel = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; sel = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_rdata", rdata, 0);
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0; sel = 3'd7;
        repeat (15) @(posedge clk);
        #1;
        check("postrst_busy", busy, 0);
        check("postrst_hi", hi, 0);
        check("postrst_lo", lo, 0);

        do_op("final_mult", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy duration of mult/multu (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy duration of div/divu (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  launch operation selected by sel.
REQ-007 SHALL have port move_to  input  1  write a into HI or LO per sel (mthi/mtlo).
REQ-008 SHALL have port sel  input  3  0=MUL, 1=MULU, 2=DIV, 3=DIVU, 4=SELECT_HI, 5=SELECT_LO, 7=none; 6 reserved.
REQ-009 SHALL have port a  input  WIDTH  rs operand / dividend / move source.
REQ-010 SHALL have port b  input  WIDTH  rt operand / divisor.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port hi  output  WIDTH  architectural HI.
REQ-013 SHALL have port lo  output  WIDTH  architectural LO.
REQ-014 SHALL have port rdata  output  WIDTH  combinational read (mfhi/mflo): hi if sel=4, lo if sel=5, else 0.

Function
REQ-015 SHALL accept start only when busy=0 and sel in 0..3; start with other sel values ignored.
REQ-016 SHALL latch a, b, sel at the accepting edge T; busy=1 from T+1 for exactly N cycles (N=MUL_CYCLES or DIV_CYCLES).
REQ-017 SHALL write HI/LO at the edge ending the N-th busy cycle; busy=0 and new hi/lo visible in the same cycle after that edge.
REQ-018 SHALL ignore start and move_to while busy=1 (upstream stall logic holds them off).
REQ-019 SHALL, for move_to with busy=0, write a to HI (sel=4) or LO (sel=5) at the next edge; other sel values ignored.
REQ-020 SHALL give start priority over move_to when both asserted with busy=0.
REQ-021 MUL: {HI,LO} = signed a * signed b, full 2*WIDTH product; MULU same with unsigned operands.
REQ-022 DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend; DIVU unsigned.
REQ-023 DIV with a = most-negative, b = -1 SHALL yield LO = most-negative, HI = 0.
REQ-024 SHALL implement a counter of width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) and states IDLE and RUN: IDLE->RUN on accepted start, RUN->IDLE when counter reaches N.
REQ-025 Result SHALL be computed from latched operands; changes on a/b/sel during RUN have no effect.

Reset
REQ-026 SHALL, on reset assertion, immediately clear hi, lo, busy, counter, latched operands and return to IDLE, including mid-operation (pending result discarded).
REQ-027 rdata SHALL read 0 during reset for sel=4/5.

Configuration
REQ-028 SHALL compile divide-by-zero guarding under macro MULDIV_DIVZERO_KEEP_EN.
REQ-029 With MULDIV_DIVZERO_KEEP_EN defined, DIV/DIVU with b=0 SHALL still go busy for DIV_CYCLES but leave HI/LO unchanged.
REQ-030 Without it, DIV/DIVU with b=0 SHALL write LO = all ones and HI = a.

Verification
REQ-031 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=2 -> LO=3, HI=1.
REQ-033 move_to sel=4 a=0x12345678, then sel=5 a=0x9ABCDEF0 -> hi/lo updated one edge later; rdata follows sel=4/5 with no extra latency.
REQ-034 start MULT, assert start DIV and move_to during busy -> both ignored, only MULT result written, busy drops after exactly 5 cycles.
REQ-035 Reset asserted at 3rd busy cycle of DIV -> busy, hi, lo = 0 immediately; no later write after reset release.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU a=5, b=0 -> HI/LO unchanged with MULDIV_DIVZERO_KEEP_EN, else LO=0xFFFFFFFF, HI=5.
